// File: rtl/kbd_tx_if.sv
// ECO32 bus responder signals for the PS/2 host-to-device transmitter.
// The slave modport is the transmitter; the master modport is the bus side.
interface kbd_tx_if;
    logic       en;
    logic       wr;
    logic       addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       wt;
    logic       irq;

    modport slave  (input en, wr, addr, data_in, output data_out, wt, irq);
    modport master (output en, wr, addr, data_in, input data_out, wt, irq);
endinterface

// File: rtl/kbd_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a start bit, then shifts
// byte/parity/stop on device clock falling edges and checks the device ACK.
module kbd_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic        clk,
    input  logic        reset,
    kbd_tx_if.slave     bus,
    output logic        busy,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_low,
    output logic        ps2_data_low
);
    localparam int ICW = $clog2(INHIBIT_CYC + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RELEASE, SEND, ACK, WAITIDLE} state_t;

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic             ien_q, ien_d;
    logic             err_q, err_d;
    logic [7:0]       byte_q, byte_d;
    logic [9:0]       shift_q, shift_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [ICW-1:0]   icnt_q, icnt_d;
    logic [TCW-1:0]   tcnt_q, tcnt_d;
    logic             clk_low_q, clk_low_d;
    logic             data_low_q, data_low_d;
    logic [2:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;

    logic fe, wr_stat, wr_data, tmo_run, timeout;

    // Idle lines are high, so the synchronizers come out of reset at 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_data_in};
        end
    end

    assign fe      = clk_sync_q[2] & ~clk_sync_q[1];
    assign wr_stat = bus.en & bus.wr & ~bus.addr;
    assign wr_data = bus.en & bus.wr & bus.addr & ready_q;
    assign tmo_run = (state_q == SEND) || (state_q == ACK) || (state_q == WAITIDLE);
    assign timeout = tmo_run && (tcnt_q == TCW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        ien_d      = ien_q;
        err_d      = err_q;
        byte_d     = byte_q;
        shift_d    = shift_q;
        bcnt_d     = bcnt_q;
        icnt_d     = icnt_q;
        tcnt_d     = tcnt_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;

        if (wr_stat) ien_d = bus.data_in[1];
        if (tmo_run) tcnt_d = tcnt_q + TCW'(1);

        case (state_q)
            IDLE: if (wr_data) begin
                byte_d    = bus.data_in;
                err_d     = 1'b0;
                shift_d   = {1'b1, ~^bus.data_in, bus.data_in};
                ready_d   = 1'b0;
                clk_low_d = 1'b1;
                icnt_d    = '0;
                state_d   = INHIBIT;
            end
            INHIBIT: begin
                icnt_d = icnt_q + ICW'(1);
                if (icnt_q == ICW'(INHIBIT_CYC - 1)) begin
                    data_low_d = 1'b1;
                    state_d    = RELEASE;
                end
            end
            RELEASE: begin
                clk_low_d = 1'b0;
                tcnt_d    = '0;
                bcnt_d    = '0;
                state_d   = SEND;
            end
            SEND: if (fe) begin
                // The stop bit is a 1, so driving it releases the data line.
                data_low_d = ~shift_q[0];
                shift_d    = {1'b0, shift_q[9:1]};
                bcnt_d     = bcnt_q + 4'd1;
                if (bcnt_q == 4'd9) state_d = ACK;
            end
            ACK: if (fe) begin
                if (dat_sync_q[1]) err_d = 1'b1;
                state_d = WAITIDLE;
            end
            WAITIDLE: if (clk_sync_q[1] && dat_sync_q[1]) begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            clk_low_d  = 1'b0;
            data_low_d = 1'b0;
            err_d      = 1'b1;
            ready_d    = 1'b1;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            ien_q      <= 1'b0;
            err_q      <= 1'b0;
            byte_q     <= 8'h00;
            shift_q    <= '0;
            bcnt_q     <= '0;
            icnt_q     <= '0;
            tcnt_q     <= '0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            ien_q      <= ien_d;
            err_q      <= err_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            bcnt_q     <= bcnt_d;
            icnt_q     <= icnt_d;
            tcnt_q     <= tcnt_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
        end
    end

    assign bus.data_out = bus.addr ? byte_q : {5'b0, err_q, ien_q, ready_q};
    assign bus.wt       = 1'b0;
    assign bus.irq      = ready_q & ien_q;
    assign busy         = (state_q != IDLE);
    assign ps2_clk_low  = clk_low_q;
    assign ps2_data_low = data_low_q;
endmodule
